// File: rtl/uart_rx_deserializer_if.sv
// UART receive-side bundle: serial line, frame configuration and byte output.
// slave is the receiver; master is whatever drives the line and reads results.
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start qualification, 3-sample majority vote,
// LSB-first reassembly, parity/stop checks and one-cycle result pulses.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    uart_rx_deserializer_if.slave  rx
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, OUT
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] pre_q;
    logic [CW-1:0]         bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  s0;
    logic                  s1;
    logic                  bit_val;
    logic                  par_fail;
    logic [DATA_WIDTH-1:0] shift;

    logic [PRESCALE_W-1:0] half;
    logic                  bit_end;
    logic                  exp_par;

    assign half    = pre_q >> 1;
    assign bit_end = (edge_cnt == pre_q - PRESCALE_W'(1));
    assign exp_par = par_typ_q ? ~(^shift) : (^shift);

    // Three samples around mid-bit; the vote is ready well before bit end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0      <= 1'b0;
            s1      <= 1'b0;
            bit_val <= 1'b0;
        end else begin
            if (edge_cnt == half - PRESCALE_W'(1))
                s0 <= rx.RX_IN;
            if (edge_cnt == half)
                s1 <= rx.RX_IN;
            if (edge_cnt == half + PRESCALE_W'(1))
                bit_val <= (s0 & s1) | (s0 & rx.RX_IN) | (s1 & rx.RX_IN);
        end
    end

    // Frame FSM; result pulses are launched on STOP exit so they line up with OUT
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            edge_cnt      <= '0;
            bit_cnt       <= '0;
            pre_q         <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            par_fail      <= 1'b0;
            shift         <= '0;
            rx.P_DATA     <= '0;
            rx.data_valid <= 1'b0;
            rx.par_err    <= 1'b0;
            rx.stp_err    <= 1'b0;
        end else begin
            rx.data_valid <= 1'b0;
            rx.par_err    <= 1'b0;
            rx.stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    par_fail <= 1'b0;
                    if (!rx.RX_IN) begin
                        state     <= START;
                        edge_cnt  <= PRESCALE_W'(1);
                        pre_q     <= rx.prescale;
                        par_en_q  <= rx.PAR_EN;
                        par_typ_q <= rx.PAR_TYP;
                    end
                end
                START: begin
                    if (bit_end) begin
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= bit_val ? IDLE : DATA;
                    end else begin
                        edge_cnt <= edge_cnt + PRESCALE_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        edge_cnt <= '0;
                        shift    <= {bit_val, shift[DATA_WIDTH-1:1]};
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else begin
                        edge_cnt <= edge_cnt + PRESCALE_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        edge_cnt <= '0;
                        par_fail <= (bit_val != exp_par);
                        state    <= STOP;
                    end else begin
                        edge_cnt <= edge_cnt + PRESCALE_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        edge_cnt <= '0;
                        state    <= OUT;
                        if (!par_fail && bit_val) begin
                            rx.P_DATA     <= shift;
                            rx.data_valid <= 1'b1;
                        end else begin
                            rx.par_err <= par_fail;
                            rx.stp_err <= ~bit_val;
                        end
                    end else begin
                        edge_cnt <= edge_cnt + PRESCALE_W'(1);
                    end
                end
                OUT: begin
                    edge_cnt <= '0;
                    state    <= IDLE;
                end
                default: begin
                    edge_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: frame table driven onto RX_IN, expected
// pulses queued at drive time and checked by a negedge monitor.
module tb_uart_rx_deserializer;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_deserializer_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .rx  (bus.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [5:0] pre;
        logic       par_en;
        logic       par_typ;
        logic [7:0] data;
        logic       bad_par;
        logic       stop;
        logic       scramble;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       dv;
        logic       pe;
        logic       se;
        int         at;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Result monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (RST && (bus.data_valid || bus.par_err || bus.stp_err)) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("data_valid", {31'd0, bus.data_valid}, {31'd0, e.dv});
                chk("par_err", {31'd0, bus.par_err}, {31'd0, e.pe});
                chk("stp_err", {31'd0, bus.stp_err}, {31'd0, e.se});
                chk("P_DATA", {24'd0, bus.P_DATA}, {24'd0, e.data});
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic dv, input logic pe,
                        input logic se, input int at);
        exp_t e;
        e.data = dv ? d : last_good;
        e.dv   = dv;
        e.pe   = pe;
        e.se   = se;
        e.at   = at;
        if (dv) last_good = d;
        sb.push_back(e);
    endtask

    // Caller is #1 after a posedge; one frame plus one idle-high cycle
    task automatic send_frame(input vec_t v, input int abort);
        logic line [0:11];
        int   n;
        int   p;
        int   c0;
        logic pe;
        logic dv;
        p = int'(v.pre);
        n = 0;
        line[n++] = 1'b0;
        for (int i = 0; i < 8; i++) line[n++] = v.data[i];
        if (v.par_en)
            line[n++] = (v.par_typ ? ~(^v.data) : (^v.data)) ^ v.bad_par;
        line[n++] = v.stop;
        c0 = cyc;
        pe = v.par_en & v.bad_par;
        dv = !pe && v.stop;
        if (abort == 0) push(v.data, dv, pe, ~v.stop, c0 + n * p);
        bus.prescale = v.pre;
        bus.PAR_EN   = v.par_en;
        bus.PAR_TYP  = v.par_typ;
        for (int j = 0; j < n * p; j++) begin
            if (abort > 0 && j == abort) return;
            bus.RX_IN = line[j / p];
            if (v.scramble && j == 2 * p) begin
                bus.prescale = 6'd12;
                bus.PAR_EN   = ~v.par_en;
                bus.PAR_TYP  = ~v.par_typ;
            end
            @(posedge CLK);
            #1;
        end
        bus.RX_IN = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    vec_t tbl[9];

    initial begin
        int   c0;
        int   pbefore;
        vec_t v;

        tbl[0] = '{6'd8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{6'd8,  1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{6'd16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{6'd16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{6'd8,  1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{6'd8,  1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{6'd32, 1'b1, 1'b1, 8'h6E, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{6'd8,  1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{6'd6,  1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0};

        bus.RX_IN    = 1'b1;
        bus.prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_P_DATA", {24'd0, bus.P_DATA}, 32'd0);
        chk("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("rst_par_err", {31'd0, bus.par_err}, 32'd0);
        chk("rst_stp_err", {31'd0, bus.stp_err}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(3);

        // Table frames, sent back to back
        for (int i = 0; i < 9; i++) send_frame(tbl[i], 0);
        idle(4);

        // Start glitch: three low cycles must not produce anything
        pbefore = pulses;
        bus.prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        idle(12);
        chk("glitch_no_pulse", pulses, pbefore);
        v = '{6'd8, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
        send_frame(v, 0);
        idle(4);

        // Break: line held low gives repeated stop errors, release yields 0xFF
        bus.prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        c0 = cyc;
        push(8'h00, 1'b0, 1'b0, 1'b1, c0 + 80);
        push(8'h00, 1'b0, 1'b0, 1'b1, c0 + 161);
        push(8'hFF, 1'b1, 1'b0, 1'b0, c0 + 242);
        bus.RX_IN = 1'b0;
        repeat (170) begin
            @(posedge CLK);
            #1;
        end
        idle(80);
        idle(4);

        // Reset in the middle of data bit 4
        v = '{6'd8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
        send_frame(v, 8 * 5 + 3);
        RST = 1'b0;
        bus.RX_IN = 1'b1;
        last_good = 8'h00;
        @(negedge CLK);
        chk("mid_rst_P_DATA", {24'd0, bus.P_DATA}, 32'd0);
        chk("mid_rst_flags",
            {29'd0, bus.data_valid, bus.par_err, bus.stp_err}, 32'd0);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(2);
        pbefore = pulses;
        v = '{6'd8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
        send_frame(v, 0);
        idle(4);
        chk("post_rst_one_pulse", pulses, pbefore + 1);

        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge CLK);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
UART receive path: the receiving end of the serial link whose transmit side shifts bytes out LSB first. It oversamples RX_IN, detects and qualifies the start bit, and majority-votes each bit. It reassembles the byte LSB first, checks the optional parity bit and the stop bit, then presents the byte to the RX-side synchronizer with a one-cycle valid pulse. It sits in the RX clock domain, downstream of the RX_IN pad synchronizer.

Parameters:
DATA_WIDTH, 8, data bits per frame.
PRESCALE_W, 6, width of the prescale input.

Ports:
CLK  input  1  oversampling clock (prescale × baud).
RST  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, already synchronized; idle high.
prescale  input  PRESCALE_W  oversampling ratio; legal values are even and ≥6; 8/16/32 verified.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WIDTH  last good received byte.
data_valid  output  1  one-cycle pulse when P_DATA is updated.
par_err  output  1  one-cycle pulse when the frame's parity is wrong.
stp_err  output  1  one-cycle pulse when the frame's stop bit is 0.

Behaviour:
- Reset is async (RST low): FSM=IDLE, all counters 0, P_DATA=0, data_valid=0, par_err=0, stp_err=0. This applies mid-frame too: the partial frame is discarded and no flag pulses.
- FSM states: IDLE, START, DATA, PARITY, STOP, OUT.
- Counters:
  - edge_cnt counts 0..prescale-1 within each bit.
  - bit_cnt counts 0..DATA_WIDTH-1 in DATA.
- IDLE: edge_cnt=0. When RX_IN=0 is sampled, go to START with edge_cnt=1; the detection cycle counts as edge 0.
- Frame configuration: prescale, PAR_EN and PAR_TYP are latched on start detection. Changes mid-frame are ignored.
- Sampling: take RX_IN at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1. The bit value is the 2-of-3 majority, registered after the third sample.
- START, at edge_cnt=prescale-1:
  - voted value 1 → glitch: return to IDLE, no flags.
  - voted value 0 → go to DATA, bit_cnt=0.
- DATA: at edge_cnt=prescale-1, shift the voted bit into the shift register LSB first (first data bit → bit 0).
  - After bit DATA_WIDTH-1: go to PARITY if PAR_EN=1, else STOP.
- PARITY: expected bit = XOR(data) for even, ~XOR(data) for odd. A mismatch sets the internal par_fail flag. At the end of the bit go to STOP.
- STOP: a voted value of 0 sets the internal stp_fail flag. At edge_cnt=prescale-1 go to OUT.
- OUT (exactly one cycle):
  - If neither par_fail nor stp_fail: P_DATA ← shift register and data_valid=1.
  - Otherwise P_DATA holds its previous value; par_err=par_fail and stp_err=stp_fail (both may pulse together).
  - Then go to IDLE.
- Outputs are registered. Latency: the data_valid/error pulse occurs in cycle (1+DATA_WIDTH+PAR_EN+1)×prescale, counting the start-detect cycle as cycle 0.
- Back-to-back frames: the next start edge is detected in IDLE on the cycle after OUT. The transmitter's stop bit lasts ≥prescale cycles, so no start edge is lost.
- The edge counter wraps to 0 at prescale-1 in every non-IDLE, non-OUT state. bit_cnt never exceeds DATA_WIDTH-1.
- RX_IN held low permanently (break): the frame yields stp_err, then IDLE immediately re-detects a start and repeats.

Test Plan:
- prescale=8, PAR_EN=1, PAR_TYP=0, frame start, 0xA5 LSB first, parity 0, stop 1 → data_valid pulse in cycle 88, P_DATA=0xA5, par_err=stp_err=0.
- prescale=16, PAR_EN=0, byte 0x3C → data_valid in cycle 160, P_DATA=0x3C. Then a back-to-back second frame 0xC3 → second pulse 160 cycles after its start edge, P_DATA=0xC3.
- prescale=8, PAR_TYP=1 (odd), byte 0x01 sent with parity bit 1 → par_err pulse in cycle 88, data_valid=0, P_DATA keeps 0xA5 from the prior frame.
- prescale=8, PAR_EN=0, byte 0xFF with stop bit 0 → stp_err pulse in cycle 80, no data_valid. Repeat with parity also wrong → par_err and stp_err pulse in the same cycle.
- Glitch: prescale=8, RX_IN low for 3 cycles then high → FSM returns to IDLE at cycle 7, no flags. A following valid frame 0x5A is received correctly.
- Drop RST during DATA bit 4, then release and send 0x81 → outputs read 0 while reset. After release, 0x81 is received with data_valid and no spurious pulse from the aborted frame.
